// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and sizing helper
// for the digit-serial adder library.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // number of DIGIT-bit slices needed to cover WIDTH bits
   function automatic int ndig(input int width, input int digit);
      return (width + digit - 1) / digit;
   endfunction

endpackage

// File: rtl/ripple_digit_adder.sv
// ripple_digit_adder: combinational DIGIT-bit ripple adder
// built from one full-adder cell per bit.
module ripple_digit_adder #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign co = c[DIGIT];

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit adder processing DIGIT bits per cycle.
// Optional macro DSA_SUBTRACT_EN adds a sub port (a-b mode).
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef DSA_SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NDIG = ndig(WIDTH, DIGIT);
   localparam int PW   = NDIG * DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CB   = WIDTH - (NDIG - 1) * DIGIT;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t              state;
   logic [CW-1:0]       ctr;
   logic                carry;
   logic [PW-1:0]       a_q;
   logic [PW-1:0]       b_q;
   logic [PW-1:0]       res;
   logic [WIDTH-1:0]    b_in;
   logic                c_in;
   logic [DIGIT-1:0]    s;
   logic                co;
   logic [DIGIT:0]      full;
   logic [PW+DIGIT-1:0] cat;
   logic                unused_bits;

`ifdef DSA_SUBTRACT_EN
   // subtract: a + ~b + 1, incoming carry is overridden
   assign b_in = sub ? ~b : b;
   assign c_in = sub | cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   ripple_digit_adder #(
      .DIGIT(DIGIT)
   ) u_digit (
      .x  (a_q[DIGIT-1:0]),
      .y  (b_q[DIGIT-1:0]),
      .ci (carry),
      .s  (s),
      .co (co)
   );

   // new digit enters at the top; after NDIG shifts the sum is aligned
   assign cat  = {s, res};
   assign full = {co, s};

   // bit WIDTH of the padded sum lives at position CB of the last digit
   assign sum         = res[WIDTH-1:0];
   assign unused_bits = ^{full, cat};

   // control FSM with operand/result shift registers and registered handshakes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         ctr       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         res       <= '0;
         cout      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= PW'(a);
                  b_q      <= PW'(b_in);
                  carry    <= c_in;
                  ctr      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               res   <= cat[PW+DIGIT-1:DIGIT];
               carry <= co;
               if (ctr == LAST) begin
                  cout      <= full[CB];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed checks of the digit-serial adder,
// 8/2 and 7/3 configurations, plus a short randomized run on 8/2.
module tb_digit_serial_adder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] sum;
   logic       cout;

   logic       in_valid7;
   logic       in_ready7;
   logic [6:0] a7;
   logic [6:0] b7;
   logic       cin7;
   logic       out_valid7;
   logic       out_ready7;
   logic [6:0] sum7;
   logic       cout7;

`ifdef DSA_SUBTRACT_EN
   logic       sub8;
   logic       sub7;
`endif

   int checks;
   int errors;

   digit_serial_adder #(
      .WIDTH(8),
      .DIGIT(2)
   ) u8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef DSA_SUBTRACT_EN
      .sub       (sub8),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   digit_serial_adder #(
      .WIDTH(7),
      .DIGIT(3)
   ) u7 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid7),
      .in_ready  (in_ready7),
      .a         (a7),
      .b         (b7),
      .cin       (cin7),
`ifdef DSA_SUBTRACT_EN
      .sub       (sub7),
`endif
      .out_valid (out_valid7),
      .out_ready (out_ready7),
      .sum       (sum7),
      .cout      (cout7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // handshake one operand set into u8, then wait for out_valid
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, output int lat,
                         output bit ir_bad);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("hs_ready", in_ready, 1);
      a        = ta;
      b        = tb;
      cin      = tc;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a        = ~ta;
      b        = ~tb;
      cin      = ~tc;
      lat      = 0;
      ir_bad   = 1'b0;
      while (!out_valid && lat < 20) begin
         if (in_ready) ir_bad = 1'b1;
         tick();
         lat++;
      end
      if (in_ready) ir_bad = 1'b1;
   endtask

   initial begin
      int         lat;
      bit         irb;
      bit         ok;
      int         n;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [8:0] e9;
      logic [6:0] ta7 [2];
      logic [6:0] tb7 [2];
      logic [6:0] es7 [2];
      logic       ec7 [2];

      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      cin        = 1'b0;
      out_ready  = 1'b0;
      in_valid7  = 1'b0;
      a7         = '0;
      b7         = '0;
      cin7       = 1'b0;
      out_ready7 = 1'b0;
`ifdef DSA_SUBTRACT_EN
      sub8       = 1'b0;
      sub7       = 1'b0;
`endif

      // reset state
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      rst = 1'b0;
      tick();

      // 1: 0xFF + 0x01, latency NDIG=4
      out_ready = 1'b1;
      run_op(8'hFF, 8'h01, 1'b0, lat, irb);
      chk("t1_lat", lat, 4);
      chk("t1_sum", sum, 8'h00);
      chk("t1_cout", cout, 1);
      tick();
      chk("t1_ov_drop", out_valid, 0);
      chk("t1_ir_back", in_ready, 1);

      // 2: 0x3C + 0x55 + 1 = 0x92
      run_op(8'h3C, 8'h55, 1'b1, lat, irb);
      chk("t2_sum", sum, 8'h92);
      chk("t2_cout", cout, 0);
      chk("t2_ir_low", irb, 0);
      tick();

      // 3: back-pressure in DONE, in_valid ignored
      out_ready = 1'b0;
      run_op(8'h12, 8'h34, 1'b0, lat, irb);
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         a        = 8'hEE;
         b        = 8'h11;
         tick();
         if (!out_valid || sum !== 8'h46 || cout !== 1'b0 || in_ready)
            ok = 1'b0;
      end
      in_valid = 1'b0;
      chk("t3_hold", ok, 1);
      out_ready = 1'b1;
      tick();
      chk("t3_ov_drop", out_valid, 0);
      chk("t3_ir_back", in_ready, 1);

      // 4: reset during second RUN cycle
      a        = 8'hAA;
      b        = 8'h11;
      cin      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("t4_in_ready", in_ready, 1);
      chk("t4_out_valid", out_valid, 0);
      chk("t4_sum", sum, 0);
      chk("t4_cout", cout, 0);
      tick();
      rst = 1'b0;
      ok  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (out_valid) ok = 1'b0;
      end
      chk("t4_no_pulse", ok, 1);
      run_op(8'h01, 8'h01, 1'b0, lat, irb);
      chk("t4_next_sum", sum, 8'h02);
      chk("t4_next_cout", cout, 0);
      tick();

      // 5: WIDTH=7 DIGIT=3, padded top digit
      ta7[0] = 7'h7F; tb7[0] = 7'h01; es7[0] = 7'h00; ec7[0] = 1'b1;
      ta7[1] = 7'h35; tb7[1] = 7'h1A; es7[1] = 7'h4F; ec7[1] = 1'b0;
      out_ready7 = 1'b1;
      for (int v = 0; v < 2; v++) begin
         chk("t5_ready", in_ready7, 1);
         a7        = ta7[v];
         b7        = tb7[v];
         cin7      = 1'b0;
         in_valid7 = 1'b1;
         tick();
         in_valid7 = 1'b0;
         n = 0;
         while (!out_valid7 && n < 20) begin
            tick();
            n++;
         end
         chk("t5_lat", n, 3);
         chk("t5_sum", sum7, es7[v]);
         chk("t5_cout", cout7, ec7[v]);
         tick();
         chk("t5_ov_drop", out_valid7, 0);
      end

`ifdef DSA_SUBTRACT_EN
      // 6: subtract mode, cin ignored
      sub8 = 1'b1;
      run_op(8'h05, 8'h07, 1'b0, lat, irb);
      chk("t6_sum_a", sum, 8'hFE);
      chk("t6_cout_a", cout, 0);
      tick();
      run_op(8'h07, 8'h05, 1'b0, lat, irb);
      chk("t6_sum_b", sum, 8'h02);
      chk("t6_cout_b", cout, 1);
      tick();
      sub8 = 1'b0;
`endif

      // randomized operands with random gaps and back-pressure
      out_ready = 1'b0;
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom_range(0, 1));
         e9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         repeat ($urandom_range(0, 2)) tick();
         run_op(ra, rb, rc, lat, irb);
         repeat ($urandom_range(0, 3)) tick();
         chk("rnd_sum", sum, e9[7:0]);
         chk("rnd_cout", cout, e9[8]);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
